// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, derived totals,
// coordinate width and the packed 8-bit RRRGGGBB colour type.
package vga_pkg;

    localparam int unsigned COORD_W = 11;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Colour fields: R[7:5], G[4:2], B[1:0]
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t COLOR_BLACK = 8'h00;
    localparam rgb_t COLOR_WHITE = 8'hFF;

endpackage

// File: rtl/vga_scanout_if.sv
// Scanout <-> renderer link: the scanout publishes the raster position and
// pixel strobes (master); the renderer returns the colour for that position
// (slave).
//   x, y        : current raster coordinate
//   pix_tick    : one-clk strobe per pixel boundary
//   frame_start : one-clk pulse when the raster wraps to (0,0)
//   rgb_in      : renderer colour for (x, y)
interface vga_scanout_if;
    import vga_pkg::*;

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               pix_tick;
    logic               frame_start;
    rgb_t               rgb_in;

    modport master (output x, y, pix_tick, frame_start, input rgb_in);
    modport slave  (input x, y, pix_tick, frame_start, output rgb_in);

endinterface

// File: rtl/vga_scanout_pix_tick_gen.sv
// Pixel clock-enable divider: tick_o is high for one clk out of every
// CLK_DIV (CLK_DIV >= 2), while the divider sits at CLK_DIV-1.
//   clk, reset : system clock, asynchronous active-high reset
//   tick_o     : registered pixel strobe
module pix_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q;

    // Divider next value
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d = '0;
        end
    end

    // Tick is decoded from the next divider value so it is registered yet
    // coincident with div == CLK_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= (div_d == DIV_W'(CLK_DIV - 1));
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing generator and pixel output stage.
// Scans an H_TOTAL x V_TOTAL raster one pixel per CLK_DIV clks, publishes
// (x, y) to the renderer and registers the returned colour together with
// hsync/vsync/active one pixel later, so syncs and colour stay aligned.
//   clk, reset          : system clock, asynchronous active-high reset
//   bus (master)        : x, y, pix_tick, frame_start out; rgb_in in
//   vga_r/vga_g/vga_b   : DAC colour pins, zero while blanked
//   hsync, vsync        : active-low syncs
//   active              : DAC pins carry a visible pixel
// Build option: VGA_BORDER_EN forces visible edge pixels to white.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               reset,
    vga_scanout_if.master      bus,
    output logic [2:0]         vga_r,
    output logic [2:0]         vga_g,
    output logic [1:0]         vga_b,
    output logic               hsync,
    output logic               vsync,
    output logic               active
);
    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic               tick;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               active_q, active_d;
    logic               frame_start_q, frame_start_d;
    rgb_t               color_q, color_d;
    rgb_t               pixel_c;

    pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    // Colour for the pixel at the pre-increment coordinate
`ifdef VGA_BORDER_EN
    logic border_c;
    assign border_c = (x_q == '0) || (x_q == X_ACT - COORD_W'(1)) ||
                      (y_q == '0) || (y_q == Y_ACT - COORD_W'(1));
    assign pixel_c  = border_c ? COLOR_WHITE : bus.rgb_in;
`else
    assign pixel_c  = bus.rgb_in;
`endif

    // Raster advance and output stage; all decode uses the coordinate being
    // left, which gives the one-pixel lag behind x/y.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        color_d       = color_q;
        frame_start_d = 1'b0;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + COORD_W'(1);
                end
            end else begin
                x_d = x_q + COORD_W'(1);
            end
            hsync_d  = !((x_q >= HS_START) && (x_q < HS_END));
            vsync_d  = !((y_q >= VS_START) && (y_q < VS_END));
            active_d = (x_q < X_ACT) && (y_q < Y_ACT);
            color_d  = active_d ? pixel_c : COLOR_BLACK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            color_q       <= COLOR_BLACK;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            color_q       <= color_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pix_tick    = tick;
    assign bus.frame_start = frame_start_q;
    assign vga_r           = color_q.r;
    assign vga_g           = color_q.g;
    assign vga_b           = color_q.b;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign active          = active_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced 15x10 raster (8x6 visible) so whole
// frames fit in a short run. A registered renderer model drives rgb_in.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam int CDIV = 4;
    localparam int HA = 8,  HF = 2, HS = 3, HB = 2;   // H_TOTAL 15
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;   // V_TOTAL 10
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * CDIV;       // 600
    localparam int BUDGET = 2 * FRAME_CLKS + 50;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] vga_r, vga_g;
    logic [1:0] vga_b;
    logic hsync, vsync, active;
    int   cyc = 0;
    int   mode = 0;
    int   total = 0;
    int   bad = 0;

    vga_scanout_if bus();

    vga_scanout #(
        .CLK_DIV(CDIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .active(active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Renderer model: one-clk registered colour lookup
    always @(posedge clk) begin
        case (mode)
            0:       bus.rgb_in <= {bus.y[3:0], bus.x[3:0]};
            1:       bus.rgb_in <= 8'hFF;
            default: bus.rgb_in <= 8'h00;
        endcase
    end

    typedef struct {
        int mode;
        int px, py;
        int hs, vs, act;
        int rgb;
        int border;
    } vec_t;
    vec_t vecs[20];

    task automatic chk(input string name, input int act_v, input int exp_v);
        total++;
        if (act_v != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act_v, exp_v);
        end
    endtask

    function automatic int color_pins();
        return int'({vga_r, vga_g, vga_b});
    endfunction

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return hsync;
            1:       return vsync;
            2:       return bus.frame_start;
            default: return bus.pix_tick;
        endcase
    endfunction

    // Advance negedges until the selected signal equals val
    task automatic wait_for(input int sel, input logic val, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (get_sig(sel) == val) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
        end
    endtask

    // Stop at the first negedge where the raster shows (px, py)
    task automatic wait_coord(input int px, input int py, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (int'(bus.x) == px && int'(bus.y) == py) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, int'(bus.x), 0);
        chk({tag, "_y"}, int'(bus.y), 0);
        chk({tag, "_tick"}, int'(bus.pix_tick), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_active"}, int'(active), 0);
        chk({tag, "_color"}, color_pins(), 0);
        chk({tag, "_fstart"}, int'(bus.frame_start), 0);
    endtask

    task automatic chk_first_tick(input string tag);
        repeat (2) @(negedge clk);
        chk({tag, "_tick_early"}, int'(bus.pix_tick), 0);
        @(negedge clk);
        chk({tag, "_tick_first"}, int'(bus.pix_tick), 1);
        chk({tag, "_x_before"}, int'(bus.x), 0);
        @(negedge clk);
        chk({tag, "_x_after"}, int'(bus.x), 1);
        chk({tag, "_tick_drop"}, int'(bus.pix_tick), 0);
    endtask

    initial begin
        int t0, t1, t2, e;
        bit ok, ok1, ok2;
        int act_cnt, leak_cnt, col_bad, hold_bad;
        int prev_out, prev_tick, cur_out;

        //             mode px py hs vs act rgb    border
        vecs[0]  = '{0, 0,  0, 1, 1, 1, 8'h00, 1};
        vecs[1]  = '{0, 3,  2, 1, 1, 1, 8'h23, 0};
        vecs[2]  = '{0, 7,  2, 1, 1, 1, 8'h27, 1};
        vecs[3]  = '{0, 8,  2, 1, 1, 0, 8'h00, 0};
        vecs[4]  = '{0, 9,  2, 1, 1, 0, 8'h00, 0};
        vecs[5]  = '{0, 10, 2, 0, 1, 0, 8'h00, 0};
        vecs[6]  = '{0, 12, 3, 0, 1, 0, 8'h00, 0};
        vecs[7]  = '{0, 13, 3, 1, 1, 0, 8'h00, 0};
        vecs[8]  = '{0, 5,  4, 1, 1, 1, 8'h45, 0};
        vecs[9]  = '{0, 2,  5, 1, 1, 1, 8'h52, 1};
        vecs[10] = '{0, 14, 5, 1, 1, 0, 8'h00, 0};
        vecs[11] = '{0, 4,  6, 1, 1, 0, 8'h00, 0};
        vecs[12] = '{0, 4,  7, 1, 0, 0, 8'h00, 0};
        vecs[13] = '{0, 11, 8, 0, 0, 0, 8'h00, 0};
        vecs[14] = '{0, 3,  9, 1, 1, 0, 8'h00, 0};
        vecs[15] = '{2, 3,  0, 1, 1, 1, 8'h00, 1};
        vecs[16] = '{2, 0,  3, 1, 1, 1, 8'h00, 1};
        vecs[17] = '{2, 3,  3, 1, 1, 1, 8'h00, 0};
        vecs[18] = '{2, 7,  3, 1, 1, 1, 8'h00, 1};
        vecs[19] = '{2, 3,  5, 1, 1, 1, 8'h00, 1};

        // Reset values and first tick after release
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        reset = 1'b0;
        chk_first_tick("rel0");

        // Table: pins reflect a coordinate exactly one pixel after it appears
        wait_for(2, 1'b1, t0, ok);
        chk("tbl_fstart_seen", int'(ok), 1);
        for (int i = 0; i < 20; i++) begin
            mode = vecs[i].mode;
            wait_coord(vecs[i].px, vecs[i].py, ok);
            chk($sformatf("tbl%0d_found", i), int'(ok), 1);
            repeat (CDIV) @(negedge clk);
            e = vecs[i].rgb;
`ifdef VGA_BORDER_EN
            if (vecs[i].border != 0) e = 8'hFF;
`endif
            chk($sformatf("tbl%0d_hsync", i), int'(hsync), vecs[i].hs);
            chk($sformatf("tbl%0d_vsync", i), int'(vsync), vecs[i].vs);
            chk($sformatf("tbl%0d_active", i), int'(active), vecs[i].act);
            chk($sformatf("tbl%0d_color", i), color_pins(), e);
        end

        // pix_tick width and period
        wait_for(3, 1'b1, t0, ok);
        wait_for(3, 1'b0, t1, ok1);
        wait_for(3, 1'b1, t2, ok2);
        chk("tick_seen", int'(ok & ok1 & ok2), 1);
        chk("tick_width", t1 - t0, 1);
        chk("tick_period", t2 - t0, CDIV);

        // hsync falls one pixel after x enters the sync region
        wait_coord(HA + HF, 1, ok);
        t0 = cyc;
        wait_for(0, 1'b0, t1, ok1);
        chk("hs_lag_seen", int'(ok & ok1), 1);
        chk("hs_lag", t1 - t0, CDIV);
        wait_for(0, 1'b1, t1, ok);
        wait_for(0, 1'b0, t2, ok1);
        chk("hs_seen", int'(ok & ok1), 1);
        chk("hs_low", t1 - (t2 - HT * CDIV), HS * CDIV);
        t0 = t2;
        wait_for(0, 1'b1, t1, ok);
        wait_for(0, 1'b0, t2, ok1);
        chk("hs_low2", t1 - t0, HS * CDIV);
        chk("hs_period", t2 - t0, HT * CDIV);

        // vsync width and period
        wait_for(1, 1'b1, t0, ok);
        wait_for(1, 1'b0, t0, ok1);
        wait_for(1, 1'b1, t1, ok2);
        wait_for(1, 1'b0, t2, ok);
        chk("vs_seen", int'(ok & ok1 & ok2), 1);
        chk("vs_low", t1 - t0, VS * HT * CDIV);
        chk("vs_period", t2 - t0, FRAME_CLKS);

        // frame_start: at (0,0), one clk wide, once per frame
        wait_for(2, 1'b1, t0, ok);
        chk("fs_x", int'(bus.x), 0);
        chk("fs_y", int'(bus.y), 0);
        @(negedge clk);
        chk("fs_width", int'(bus.frame_start), 0);
        wait_for(2, 1'b1, t1, ok1);
        chk("fs_seen", int'(ok & ok1), 1);
        chk("fs_period", t1 - t0, FRAME_CLKS);

        // Blanking and output cadence over one full frame of white input
        mode = 1;
        wait_for(2, 1'b1, t0, ok);
        chk("blank_fs_seen", int'(ok), 1);
        act_cnt = 0; leak_cnt = 0; col_bad = 0; hold_bad = 0;
        prev_out = -1; prev_tick = 0;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            @(negedge clk);
            cur_out = int'({hsync, vsync, active, vga_r, vga_g, vga_b});
            if (active) begin
                act_cnt++;
                if (color_pins() != 8'hFF) col_bad++;
            end else if (color_pins() != 0) begin
                leak_cnt++;
            end
            if (prev_out >= 0 && cur_out != prev_out && prev_tick == 0) hold_bad++;
            prev_out  = cur_out;
            prev_tick = int'(bus.pix_tick);
        end
        chk("blank_active_clks", act_cnt, HA * VA * CDIV);
        chk("blank_leak", leak_cnt, 0);
        chk("blank_color", col_bad, 0);
        chk("out_hold", hold_bad, 0);

        // Asynchronous reset mid-frame, away from any clock edge
        mode = 0;
        wait_coord(4, 3, ok);
        chk("mid_found", int'(ok), 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("rst1");
        repeat (2) @(negedge clk);
        chk_reset_vals("rst1_hold");
        reset = 1'b0;
        chk_first_tick("rel1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
